// File: rtl/axi_fifo_pkg.sv
// axi_fifo_pkg: AXI length/response constants and write-channel beat types for axi_wr_fifo.
package axi_fifo_pkg;
  localparam int AXI_LEN_W = 8;
  localparam int AXI_MAX_BEATS = 256;
  localparam int AXI_RESP_W = 2;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;
  localparam int AXI_ID_W = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0] len;
  } aw_beat;
  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic last;
  } w_beat;
  function automatic int burst_beats(input logic [AXI_LEN_W-1:0] len);
    return int'(len) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers, registered not_full and zeroed output when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     not_full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = {1'b1, {PW{1'b0}}};
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wptr, rptr, wptr_n, rptr_n;
  logic not_empty, do_push, do_pop;
  assign not_empty = wptr != rptr;
  assign do_push = push & not_full;
  assign do_pop = pop & not_empty;
  assign wptr_n = wptr + {{PW{1'b0}}, do_push};
  assign rptr_n = rptr + {{PW{1'b0}}, do_pop};
  assign level = wptr - rptr;
  assign dout = not_empty ? mem[rptr[PW-1:0]] : '0;
  // ready is computed from the next-state occupancy so it is a pure register output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      not_full <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      not_full <= (wptr_n - rptr_n) != FULL_LVL;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/axi_wr_fifo.sv
// axi_wr_fifo: buffers AXI AW and W channels through independent FIFOs.
// Define AXI_WR_FIFO_PKT_MODE_EN for store-and-forward (bursts released only once complete).
module axi_wr_fifo
  import axi_fifo_pkg::*;
#(
  parameter int ID_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_DEPTH = 4,
  parameter int W_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]        s_axi_awlen,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [DATA_WIDTH-1:0]       s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]     s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [ID_WIDTH-1:0]         m_axi_awid,
  output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]        m_axi_awlen,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [$clog2(W_DEPTH):0]    w_level
);
  localparam int AWW = ID_WIDTH + ADDR_WIDTH + AXI_LEN_W;
  localparam int WW = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int CW = $clog2(W_DEPTH) + 1;
  logic [AWW-1:0] aw_dout;
  logic [WW-1:0] w_dout;
  logic [$clog2(AW_DEPTH):0] aw_level;
  logic aw_push, aw_pop, w_push, w_pop, fwd;
  assign aw_push = s_axi_awvalid & s_axi_awready;
  assign aw_pop = m_axi_awvalid & m_axi_awready;
  assign w_push = s_axi_wvalid & s_axi_wready;
  assign w_pop = m_axi_wvalid & m_axi_wready;
  assign m_axi_awvalid = (aw_level != '0) & fwd;
  assign m_axi_wvalid = (w_level != '0) & fwd;
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen} = aw_dout;
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_dout;
`ifdef AXI_WR_FIFO_PKT_MODE_EN
  // count of complete bursts resident in the W FIFO; bursts above W_DEPTH beats can never complete
  logic [CW-1:0] bursts;
  logic inc, dec;
  assign inc = w_push & s_axi_wlast;
  assign dec = w_pop & m_axi_wlast;
  assign fwd = bursts != '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bursts <= '0;
    else if (inc != dec) bursts <= inc ? bursts + {{(CW-1){1'b0}}, 1'b1} : bursts - {{(CW-1){1'b0}}, 1'b1};
  end
`else
  assign fwd = 1'b1;
`endif
  sync_fifo #(.WIDTH(AWW), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk),
    .rst(rst),
    .push(aw_push),
    .din({s_axi_awid, s_axi_awaddr, s_axi_awlen}),
    .not_full(s_axi_awready),
    .pop(aw_pop),
    .dout(aw_dout),
    .level(aw_level)
  );
  sync_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .din({s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
    .not_full(s_axi_wready),
    .pop(w_pop),
    .dout(w_dout),
    .level(w_level)
  );
endmodule

// File: tb/tb_axi_wr_fifo.sv
// tb_axi_wr_fifo: directed and randomized checks of axi_wr_fifo against a queue-based reference model.
module tb_axi_wr_fifo;
  import axi_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0] s_axi_awlen = '0;
  logic s_axi_awvalid = 1'b0;
  logic s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 1'b0;
  logic s_axi_wvalid = 1'b0;
  logic s_axi_wready;
  logic [7:0] m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic m_axi_awvalid;
  logic m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0] m_axi_wstrb;
  logic m_axi_wlast;
  logic m_axi_wvalid;
  logic m_axi_wready = 1'b0;
  logic [4:0] w_level;
  int n_cmp = 0;
  int n_err = 0;
  int w_out = 0;
  int aw_out = 0;
  bit live = 1'b0;
  w_beat q_w[$];
  aw_beat q_aw[$];

  axi_wr_fifo dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .w_level(w_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a queued burst may leave only once its last beat is buffered in store-and-forward mode
  function automatic bit may_forward();
`ifdef AXI_WR_FIFO_PKT_MODE_EN
    foreach (q_w[i]) if (q_w[i].last) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst) live <= rst;

  always @(negedge clk) begin
    if (!rst) begin
      q_w.delete();
      q_aw.delete();
    end
    chk("w_level", w_level, q_w.size());
    chk("s_wready", s_axi_wready, live && q_w.size() < 16);
    chk("s_awready", s_axi_awready, live && q_aw.size() < 4);
    chk("m_wvalid", m_axi_wvalid, q_w.size() != 0 && may_forward());
    chk("m_awvalid", m_axi_awvalid, q_aw.size() != 0 && may_forward());
    if (m_axi_wvalid && q_w.size() != 0) begin
      chk("w_payload", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, q_w[0]);
      if (m_axi_wready) begin
        void'(q_w.pop_front());
        w_out++;
      end
    end
    if (m_axi_awvalid && q_aw.size() != 0) begin
      chk("aw_payload", {m_axi_awid, m_axi_awaddr, m_axi_awlen}, q_aw[0]);
      if (m_axi_awready) begin
        void'(q_aw.pop_front());
        aw_out++;
      end
    end
    if (s_axi_wvalid && s_axi_wready) q_w.push_back('{s_axi_wdata, s_axi_wstrb, s_axi_wlast});
    if (s_axi_awvalid && s_axi_awready) q_aw.push_back('{s_axi_awid, s_axi_awaddr, s_axi_awlen});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_axi_awid = id;
    s_axi_awaddr = addr;
    s_axi_awlen = len;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic last);
    s_axi_wdata = data;
    s_axi_wstrb = 4'hF;
    s_axi_wlast = last;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
  endtask

  task automatic drain();
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    for (int i = 0; i < 200 && (w_level != 0 || m_axi_awvalid); i++) tick();
    chk("drain_w", w_level, 0);
    chk("drain_aw", m_axi_awvalid, 0);
  endtask

  initial begin
    int base;
    int pushed;
    #2 rst = 1'b0;
    #1;
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_level", w_level, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    tick();
    tick();
    rst = 1'b1;
    chk("rel_wready", s_axi_wready, 0);
    tick();
    chk("rel_wready_up", s_axi_wready, 1);
    chk("rel_awready_up", s_axi_awready, 1);

    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    s_axi_awid = 8'h01;
    s_axi_awaddr = 32'h1000;
    s_axi_awlen = 8'h00;
    s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1;
    s_axi_wstrb = 4'hF;
    s_axi_wlast = 1'b1;
    s_axi_wvalid = 1'b1;
    chk("no_bypass", m_axi_wvalid, 0);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    chk("single_awvalid", m_axi_awvalid, 1);
    chk("single_awid", m_axi_awid, 8'h01);
    chk("single_awaddr", m_axi_awaddr, 32'h1000);
    chk("single_wdata", m_axi_wdata, 32'h1);
    chk("single_wlast", m_axi_wlast, 1);
    tick();
    chk("single_gone", m_axi_wvalid, 0);

    m_axi_wready = 1'b0;
    for (int i = 0; i < 16; i++) send_w(32'(i), i == 15);
    chk("fill_wready", s_axi_wready, 0);
    chk("fill_level", w_level, 16);
    m_axi_wready = 1'b1;
    s_axi_wdata = 32'h99;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    m_axi_wready = 1'b0;
    chk("fullpop_level", w_level, 15);
    chk("fullpop_wready", s_axi_wready, 1);
    chk("fullpop_head", m_axi_wdata, 32'h1);
    base = w_out;
    drain();
    chk("fill_drained", w_out - base, 15);

    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    send_aw(8'h02, 32'h2000, 8'd3);
`ifdef AXI_WR_FIFO_PKT_MODE_EN
    chk("pkt_aw_held", m_axi_awvalid, 0);
`else
    chk("ct_aw_early", m_axi_awvalid, 1);
`endif
    for (int i = 0; i < 3; i++) send_w(32'h10 + 32'(i), 1'b0);
`ifdef AXI_WR_FIFO_PKT_MODE_EN
    chk("pkt_aw_partial", m_axi_awvalid, 0);
`else
    chk("ct_aw_partial", m_axi_awvalid, 1);
`endif
    send_w(32'h13, 1'b1);
    chk("burst_awvalid", m_axi_awvalid, 1);
    chk("burst_awlen", m_axi_awlen, 8'd3);
    chk("burst_head", m_axi_wdata, 32'h10);
    drain();

    m_axi_awready = 1'b0;
    for (int i = 0; i < 4; i++) send_aw(8'(i), 32'h4000 + 32'(i * 16), 8'd0);
    chk("aw_full", s_axi_awready, 0);
    drain();

    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    send_aw(8'h03, 32'h3000, 8'd3);
    send_w(32'h20, 1'b0);
    send_w(32'h21, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_wvalid", m_axi_wvalid, 0);
    chk("midrst_awvalid", m_axi_awvalid, 0);
    chk("midrst_level", w_level, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_stale", m_axi_wvalid, 0);
    chk("post_rst_wready", s_axi_wready, 1);
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    base = w_out;
    send_aw(8'h04, 32'h5000, 8'd3);
    for (int i = 0; i < 4; i++) send_w(32'h30 + 32'(i), i == 3);
    drain();
    chk("post_rst_count", w_out - base, 4);

    base = w_out;
    pushed = 0;
    for (int c = 0; c < 800 && pushed < 40; c++) begin
      m_axi_wready = c[0];
      s_axi_wvalid = $urandom_range(3) != 0;
      s_axi_wdata = $urandom;
      s_axi_wstrb = 4'($urandom);
      s_axi_wlast = (pushed % 4) == 3;
      if (s_axi_wvalid && s_axi_wready) pushed++;
      tick();
    end
    s_axi_wvalid = 1'b0;
    chk("wrap_pushed", pushed, 40);
    drain();
    chk("wrap_count", w_out - base, 40);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_wr_fifo.md
AXI_WR_FIFO -- requirements
Module: axi_wr_fifo

Interface
REQ-001 The block SHALL have parameters, one per line, as follows:
- ID_WIDTH, default 8: AXI ID width.
- ADDR_WIDTH, default 32: address width.
- DATA_WIDTH, default 32: W data width; a multiple of 8.
- AW_DEPTH, default 4: AW FIFO entries; a power of two, at least 2.
- W_DEPTH, default 16: W FIFO entries; a power of two, at least 2.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- s_axi_awid / s_axi_awaddr / s_axi_awlen  in  ID_WIDTH / ADDR_WIDTH / 8  slave write-address payload.
- s_axi_awvalid  in  1  slave AW valid.
- s_axi_awready  out  1  slave AW ready.
- s_axi_wdata / s_axi_wstrb / s_axi_wlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  slave write-data payload.
- s_axi_wvalid  in  1  slave W valid.
- s_axi_wready  out  1  slave W ready.
- m_axi_awid / m_axi_awaddr / m_axi_awlen  out  widths as slave  master AW payload.
- m_axi_awvalid  out  1  master AW valid.
- m_axi_awready  in  1  master AW ready.
- m_axi_wdata / m_axi_wstrb / m_axi_wlast  out  widths as slave  master W payload.
- m_axi_wvalid  out  1  master W valid.
- m_axi_wready  in  1  master W ready.
- w_level  out  $clog2(W_DEPTH)+1  current W FIFO occupancy.

Function
REQ-003 A beat SHALL transfer on any channel only in a cycle where valid and ready are both high at the rising edge.
REQ-004 The AW and W channels SHALL each be buffered by an independent FIFO; payload SHALL leave in arrival order and unmodified.
REQ-005 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL be presented on the master side with valid high after edge N, when that FIFO was empty.
REQ-006 s_axi_awready SHALL equal not-full of the AW FIFO, and s_axi_wready SHALL equal not-full of the W FIFO; both SHALL be registered, not derived from any input.
REQ-007 Full FIFO with simultaneous pop: the pop SHALL complete, no push SHALL occur in that cycle, and ready SHALL rise the next cycle.
REQ-008 Empty FIFO with simultaneous push: the beat SHALL NOT bypass to the master side in the same cycle.
REQ-009 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL both complete, leaving the occupancy unchanged.
REQ-010 Read and write pointers SHALL wrap modulo depth, with one extra bit distinguishing full from empty.
REQ-011 Master-side valid SHALL hold and payload SHALL remain stable while ready is low.
REQ-012 w_level SHALL increment on push-only, decrement on pop-only, and remain unchanged otherwise; it SHALL never exceed W_DEPTH.

Reset
REQ-013 While rst is low, all pointers, counters and w_level SHALL be 0, and all valid and ready outputs SHALL be 0.
REQ-014 Payload outputs SHALL reset to 0.
REQ-015 s_axi_awready and s_axi_wready SHALL go high on the first rising edge after rst deasserts.
REQ-016 Reset asserted mid-burst SHALL discard all buffered beats; no partial burst SHALL be emitted after release.

Configuration
REQ-017 When macro AXI_WR_FIFO_PKT_MODE_EN is defined, the block SHALL operate in store-and-forward mode:
- A complete-burst counter SHALL increment on each accepted s_axi_wlast beat and decrement on each accepted m_axi_wlast beat.
- When both occur in the same cycle, the counter SHALL remain unchanged.
- m_axi_awvalid and m_axi_wvalid SHALL be asserted only while the counter is non-zero.
- A burst longer than W_DEPTH SHALL deadlock; this is a documented restriction, and awlen+1 SHALL NOT exceed W_DEPTH.
REQ-018 When AXI_WR_FIFO_PKT_MODE_EN is not defined, the block SHALL operate in cut-through mode: valid SHALL follow FIFO non-empty, and no burst counter SHALL be built.

Structure
REQ-019 Package axi_fifo_pkg SHALL hold the AXI length and response constants, and the aw_beat and w_beat payload struct typedefs.
REQ-020 A single parametrised sub-module, sync_fifo (WIDTH, DEPTH), SHALL be instantiated twice: once for AW and once for W.

Verification
REQ-021 The bench SHALL cover these directed scenarios, at minimum:
- After reset: single AW (id 0x01, addr 0x1000, len 0) plus W 0x0000_0001 with wlast, master ready high -> both appear on the master side 1 cycle later, unchanged.
- Fill test: m_axi_wready held low, push 16 W beats 0x0000..0x000F -> s_axi_wready low after the 16th beat; w_level = 16; then drain in order 0x0000..0x000F.
- Full with simultaneous pop: full W FIFO, m_axi_wready=1 and s_axi_wvalid=1 for one cycle -> exactly one pop, no push, w_level = 15, s_axi_wready high the next cycle.
- Packet mode: AW with len 3, W beats 0x10..0x12 without wlast -> m_axi_awvalid stays 0; on the fourth beat 0x13 with wlast -> m_axi_awvalid=1 next cycle. In cut-through mode: m_axi_awvalid=1 one cycle after the AW is accepted.
- Reset mid-burst: rst low after 2 of 4 beats -> all valids 0 and w_level=0; after release, a new burst passes cleanly with no stale data.
- Pointer wrap: 40 beats streamed with alternating master-ready stalls -> output sequence identical to input sequence, no loss or duplication.
